// File: rtl/stat_disp_pkg.sv
// Shared constants and types for the performance-counter display scheduler.
package stat_disp_pkg;

  localparam logic [1:0] SEL_TOTAL   = 2'd0;
  localparam logic [1:0] SEL_UNCTRL  = 2'd1;
  localparam logic [1:0] SEL_CTRL    = 2'd2;
  localparam logic [1:0] SEL_LOADUSE = 2'd3;

  localparam int unsigned NUM_DIGITS = 8;
  localparam logic [7:0]  BLANK      = 8'hFF;

  typedef logic [2:0] digit_t;

  typedef enum logic {
    IDLE,
    PENDING
  } step_state_t;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment glyph (bit order g..a).
module hex7seg (
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/stat_display_ctrl.sv
// Scans one of four 32-bit performance counters onto an 8-digit seven-segment
// display, with button-stepped or auto-rotating counter selection.
module stat_display_ctrl
  import stat_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV      = 100000,
  parameter int unsigned ROTATE_FRAMES = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] total_cycle,
  input  logic [31:0] num_uncontrol,
  input  logic [31:0] num_control,
  input  logic [31:0] num_loaduse,
  input  logic        next_btn,
  input  logic        auto_en,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic [1:0]  sel
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FW = $clog2(ROTATE_FRAMES + 1);

  logic [PW-1:0] presc;
  logic          tick;
  digit_t        digit;
  logic          frame_end;
  logic          btn_prev;
  logic          btn_rise;
  logic [FW-1:0] fcnt;
  logic          auto_due;
  logic          advance;
  logic [1:0]    sel_nxt;
  logic [31:0]   shadow;
  logic [31:0]   pick;
  logic          started;
  logic [3:0]    nibble;
  logic [6:0]    glyph;

  step_state_t state, state_nxt;

  assign tick      = (presc == PW'(SCAN_DIV - 1));
  assign frame_end = tick && (digit == 3'd7);
  assign btn_rise  = next_btn && !btn_prev;
  assign auto_due  = auto_en && (fcnt == FW'(ROTATE_FRAMES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc    <= '0;
      digit    <= 3'd7;
      btn_prev <= 1'b0;
      started  <= 1'b0;
    end else begin
      presc    <= tick ? '0 : presc + 1'b1;
      btn_prev <= next_btn;
      if (tick) begin
        digit   <= digit + 3'd1;
        started <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // An edge arriving on the boundary cycle itself re-arms PENDING for the next frame.
  always_comb begin
    state_nxt = state;
    advance   = 1'b0;
    if (frame_end) begin
      advance   = (state == PENDING) || auto_due;
      state_nxt = btn_rise ? PENDING : IDLE;
    end else if (btn_rise) begin
      state_nxt = PENDING;
    end
  end

  assign sel_nxt = sel + {1'b0, advance};

  always_comb begin
    pick = total_cycle;
    case (sel_nxt)
      SEL_TOTAL:   pick = total_cycle;
      SEL_UNCTRL:  pick = num_uncontrol;
      SEL_CTRL:    pick = num_control;
      SEL_LOADUSE: pick = num_loaduse;
      default:     pick = total_cycle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel    <= SEL_TOTAL;
      shadow <= '0;
      fcnt   <= '0;
    end else begin
      if (frame_end) begin
        sel    <= sel_nxt;
        shadow <= pick;
      end
      if (!auto_en)       fcnt <= '0;
      else if (frame_end) fcnt <= advance ? '0 : fcnt + 1'b1;
    end
  end

  assign nibble = shadow[4*digit +: 4];

  hex7seg u_hex (
    .nib (nibble),
    .seg (glyph)
  );

  // Outputs stay blank until the first tick has moved the scan onto digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= BLANK;
      seg <= BLANK;
    end else if (started) begin
      an  <= ~(8'b1 << digit);
      seg <= {(digit != {1'b0, sel}), glyph};
    end
  end

endmodule

// File: tb/tb_stat_display_ctrl.sv
// Directed, table-driven bench for stat_display_ctrl with SCAN_DIV=4, ROTATE_FRAMES=2.
module tb_stat_display_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] total_cycle, num_uncontrol, num_control, num_loaduse;
  logic        next_btn, auto_en;
  logic [7:0]  an, seg;
  logic [1:0]  sel;

  int unsigned nvec = 0;
  int unsigned nerr = 0;
  int unsigned cyc  = 0;
  int unsigned base = 0;

  stat_display_ctrl #(.SCAN_DIV(4), .ROTATE_FRAMES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .total_cycle   (total_cycle),
    .num_uncontrol (num_uncontrol),
    .num_control   (num_control),
    .num_loaduse   (num_loaduse),
    .next_btn      (next_btn),
    .auto_en       (auto_en),
    .an            (an),
    .seg           (seg),
    .sel           (sel)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned edge_no;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic [1:0]  sel;
    logic [31:0] drive_total;
  } vec_t;

  typedef struct {
    int unsigned edge_no;
    logic [1:0]  sel;
  } selvec_t;

  vec_t    scan_tbl[16];
  selvec_t rot_tbl[8];

  // Wait until k posedges since reset release have been processed, then 1 time unit.
  task automatic wait_until(input int unsigned k);
    while ((cyc - base) < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @edge %0d: got %h expected %h", name, cyc - base, act, exp);
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst  = 1'b0;
    base = cyc;
  endtask

  task automatic pulse_btn(input int unsigned at, input int unsigned len);
    wait_until(at);
    next_btn = 1'b1;
    wait_until(at + len);
    next_btn = 1'b0;
  endtask

  initial begin
    // frame 0: 0x12345678, sel 0; total changes to FFFFFFFF after digit 3 is shown
    scan_tbl[0]  = '{5,  8'hFE, 8'h00, 2'd0, 32'h12345678};
    scan_tbl[1]  = '{9,  8'hFD, 8'hF8, 2'd0, 32'h12345678};
    scan_tbl[2]  = '{13, 8'hFB, 8'h82, 2'd0, 32'h12345678};
    scan_tbl[3]  = '{17, 8'hF7, 8'h92, 2'd0, 32'hFFFFFFFF};
    scan_tbl[4]  = '{21, 8'hEF, 8'h99, 2'd0, 32'hFFFFFFFF};
    scan_tbl[5]  = '{25, 8'hDF, 8'hB0, 2'd0, 32'hFFFFFFFF};
    scan_tbl[6]  = '{29, 8'hBF, 8'hA4, 2'd0, 32'hFFFFFFFF};
    scan_tbl[7]  = '{33, 8'h7F, 8'hF9, 2'd0, 32'hFFFFFFFF};
    scan_tbl[8]  = '{37, 8'hFE, 8'h0E, 2'd0, 32'hFFFFFFFF};
    scan_tbl[9]  = '{41, 8'hFD, 8'h8E, 2'd0, 32'hFFFFFFFF};
    scan_tbl[10] = '{45, 8'hFB, 8'h8E, 2'd0, 32'hFFFFFFFF};
    scan_tbl[11] = '{49, 8'hF7, 8'h8E, 2'd0, 32'hFFFFFFFF};
    scan_tbl[12] = '{53, 8'hEF, 8'h8E, 2'd0, 32'hFFFFFFFF};
    scan_tbl[13] = '{57, 8'hDF, 8'h8E, 2'd0, 32'hFFFFFFFF};
    scan_tbl[14] = '{61, 8'hBF, 8'h8E, 2'd0, 32'hFFFFFFFF};
    scan_tbl[15] = '{65, 8'h7F, 8'h8E, 2'd0, 32'hFFFFFFFF};

    // auto-rotation: boundaries every 32 edges, advance every second frame
    rot_tbl[0] = '{196, 2'd2};
    rot_tbl[1] = '{228, 2'd3};
    rot_tbl[2] = '{260, 2'd3};
    rot_tbl[3] = '{292, 2'd0};
    rot_tbl[4] = '{324, 2'd0};
    rot_tbl[5] = '{356, 2'd1};
    rot_tbl[6] = '{388, 2'd1};
    rot_tbl[7] = '{420, 2'd2};

    rst           = 1'b1;
    total_cycle   = 32'h12345678;
    num_uncontrol = 32'h0000000A;
    num_control   = 32'h22222222;
    num_loaduse   = 32'h0000000C;
    next_btn      = 1'b0;
    auto_en       = 1'b0;

    // reset and first frame
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_sel", sel, 2'd0);
    release_rst();
    wait_until(3);
    chk("pre_tick_an", an, 8'hFF);
    wait_until(4);
    chk("tick_edge_an", an, 8'hFF);

    // full frame scan plus tearing check
    for (int i = 0; i < 16; i++) begin
      wait_until(scan_tbl[i].edge_no);
      chk($sformatf("scan%0d_an", i), an, scan_tbl[i].an);
      chk($sformatf("scan%0d_seg", i), seg, scan_tbl[i].seg);
      chk($sformatf("scan%0d_sel", i), sel, scan_tbl[i].sel);
      total_cycle = scan_tbl[i].drive_total;
    end

    // two pulses within frame 2 coalesce into one step at edge 100
    pulse_btn(72, 2);
    pulse_btn(84, 3);
    wait_until(99);
    chk("coal_pre_sel", sel, 2'd0);
    wait_until(100);
    chk("coal_sel", sel, 2'd1);
    wait_until(101);
    chk("coal_d0_seg", seg, 8'h88);
    wait_until(105);
    chk("coal_d1_an", an, 8'hFD);
    chk("coal_d1_seg", seg, 8'h40);
    wait_until(109);
    chk("coal_d2_seg", seg, 8'hC0);

    // edge on the boundary cycle is deferred one frame
    wait_until(131);
    next_btn = 1'b1;
    wait_until(132);
    chk("late_btn_sel132", sel, 2'd1);
    wait_until(140);
    next_btn = 1'b0;
    wait_until(164);
    chk("late_btn_sel164", sel, 2'd2);
    wait_until(170);
    auto_en = 1'b1;

    // auto rotation, with a button pulse in the frame of the auto advance at 356
    for (int i = 0; i < 8; i++) begin
      if (rot_tbl[i].edge_no == 356) pulse_btn(330, 2);
      wait_until(rot_tbl[i].edge_no);
      chk($sformatf("rot%0d_sel", i), sel, rot_tbl[i].sel);
      if (rot_tbl[i].edge_no == 228) begin
        wait_until(229);
        chk("rot_loaduse_seg", seg, 8'hC6);
      end
    end

    // asynchronous reset mid-frame, between clock edges at digit 5
    wait_until(442);
    chk("pre_arst_an", an, 8'hDF);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_an", an, 8'hFF);
    chk("arst_seg", seg, 8'hFF);
    chk("arst_sel", sel, 2'd0);
    auto_en = 1'b0;
    repeat (2) @(posedge clk);
    release_rst();
    wait_until(4);
    chk("rerun_tick_an", an, 8'hFF);
    wait_until(5);
    chk("rerun_an", an, 8'hFE);
    chk("rerun_seg", seg, 8'h0E);
    chk("rerun_sel", sel, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
